// File: rtl/cordic_rotation_core.sv
// Purpose: iterative rotation-mode CORDIC; turns a first-quadrant angle into cos/sin (x/y) and carries the quadrant tag through unchanged.
// Latency: out_valid rises ITERATIONS cycles after the accepting edge; one IDLE cycle separates back-to-back jobs.
// Backpressure: one job in flight; in_ready is low while busy and the result is held in DONE until out_ready.
// Build option: define CORDIC_ROUND_EN for round-to-nearest shift terms (default build truncates).
module cordic_rotation_core #(
   parameter int WIDTH      = 20,
   parameter int ITERATIONS = 16,
   parameter int K_INIT     = 159188
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] angle_in,
   input  logic [2:0]              quadrant_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] x_out,
   output logic signed [WIDTH-1:0] y_out,
   output logic [2:0]              quadrant_out
);

   localparam int            IW   = $clog2(ITERATIONS + 1);
   localparam logic [IW-1:0] LAST = IW'(ITERATIONS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ROTATE,
      DONE
   } state_t;

   state_t                  state;
   state_t                  state_nxt;

   logic signed [WIDTH-1:0] x_q;
   logic signed [WIDTH-1:0] y_q;
   logic signed [WIDTH-1:0] z_q;
   logic [IW-1:0]           i_q;
   logic [2:0]              quad_q;

   logic signed [WIDTH-1:0] x_sh;
   logic signed [WIDTH-1:0] y_sh;
   logic signed [WIDTH-1:0] atan_v;
   logic signed [WIDTH-1:0] x_nxt;
   logic signed [WIDTH-1:0] y_nxt;
   logic signed [WIDTH-1:0] z_nxt;

   // atan(2^-i) in Q1.18, rounded to nearest; entries cover the full legal iteration range.
   function automatic logic signed [WIDTH-1:0] atan_rom(input logic [IW-1:0] idx);
      int v;
      case (int'(idx))
         0:       v = 205887;
         1:       v = 121543;
         2:       v = 64220;
         3:       v = 32599;
         4:       v = 16363;
         5:       v = 8189;
         6:       v = 4096;
         7:       v = 2048;
         8:       v = 1024;
         9:       v = 512;
         10:      v = 256;
         11:      v = 128;
         12:      v = 64;
         13:      v = 32;
         14:      v = 16;
         15:      v = 8;
         16:      v = 4;
         17:      v = 2;
         default: v = 0;
      endcase
      return WIDTH'(v);
   endfunction

   // Scaled cross term v * 2^-sh; rounding removes the downward bias of a plain arithmetic shift.
   function automatic logic signed [WIDTH-1:0] shift_term(input logic signed [WIDTH-1:0] v,
                                                          input logic [IW-1:0]           sh);
`ifdef CORDIC_ROUND_EN
      logic signed [WIDTH-1:0] bias;
      if (sh == '0) begin
         return v;
      end
      bias = WIDTH'(1) << (sh - IW'(1));
      return (v + bias) >>> sh;
`else
      return v >>> sh;
`endif
   endfunction

   // One micro-rotation: direction follows the sign of the residual angle; all sums wrap at WIDTH bits.
   always_comb begin
      x_sh   = shift_term(x_q, i_q);
      y_sh   = shift_term(y_q, i_q);
      atan_v = atan_rom(i_q);
      x_nxt  = x_q;
      y_nxt  = y_q;
      z_nxt  = z_q;
      if (!z_q[WIDTH-1]) begin
         x_nxt = x_q - y_sh;
         y_nxt = y_q + x_sh;
         z_nxt = z_q - atan_v;
      end else begin
         x_nxt = x_q + y_sh;
         y_nxt = y_q - x_sh;
         z_nxt = z_q + atan_v;
      end
   end

   // State register; reset abandons any job in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs, decoded purely from the current state.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = ROTATE;
            end
         end
         ROTATE: begin
            if (i_q == LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: load on acceptance, iterate in ROTATE, publish results on the final iteration edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q          <= '0;
         y_q          <= '0;
         z_q          <= '0;
         i_q          <= '0;
         quad_q       <= '0;
         x_out        <= '0;
         y_out        <= '0;
         quadrant_out <= '0;
      end else if (state == IDLE) begin
         if (in_valid) begin
            x_q    <= WIDTH'(K_INIT);
            y_q    <= '0;
            z_q    <= angle_in;
            quad_q <= quadrant_in;
            i_q    <= '0;
         end
      end else if (state == ROTATE) begin
         x_q <= x_nxt;
         y_q <= y_nxt;
         z_q <= z_nxt;
         i_q <= i_q + IW'(1);
         if (i_q == LAST) begin
            x_out        <= x_nxt;
            y_out        <= y_nxt;
            quadrant_out <= quad_q;
         end
      end
   end

endmodule

// File: tb/tb_cordic_rotation_core.sv
// Bench for cordic_rotation_core: directed jobs with a scoreboard of ideal cos/sin values.
// Expected results are computed from real-valued trig at drive time and popped when a result is offered.
// Covers reset, latency, backpressure, ignored input while busy, and reset in mid-rotation.
module tb_cordic_rotation_core;

   localparam int WIDTH      = 20;
   localparam int ITERATIONS = 16;
   localparam int TOL        = 16;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] angle_in;
   logic [2:0]              quadrant_in;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] x_out;
   logic signed [WIDTH-1:0] y_out;
   logic [2:0]              quadrant_out;

   typedef struct {
      int quad;
      int exp_x;
      int exp_y;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cnt;

   cordic_rotation_core #(
      .WIDTH     (WIDTH),
      .ITERATIONS(ITERATIONS),
      .K_INIT    (159188)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .angle_in    (angle_in),
      .quadrant_in (quadrant_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .x_out       (x_out),
      .y_out       (y_out),
      .quadrant_out(quadrant_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input logic signed [31:0] obs, input int exp);
      n_checks++;
      assert (!$isunknown(obs) && (obs >= exp - TOL) && (obs <= exp + TOL))
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, TOL);
      end
   endtask

   function automatic int to_fix(input real r);
      if (r >= 0.0) return $rtoi(r * 262144.0 + 0.5);
      else          return -$rtoi(-r * 262144.0 + 0.5);
   endfunction

   // One full job: acceptance, optional busy-time poke, latency, optional backpressure, scoreboard compare.
   task automatic do_job(input int angle, input int quad, input int bp, input bit poke);
      exp_t                    e;
      int                      n;
      real                     a;
      logic signed [WIDTH-1:0] hx;
      logic signed [WIDTH-1:0] hy;
      logic [2:0]              hq;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check_eq("ready_before_job", in_ready, 1);
      a       = real'(angle) / 262144.0;
      e.quad  = quad;
      e.exp_x = to_fix($cos(a));
      e.exp_y = to_fix($sin(a));
      sb.push_back(e);
      angle_in    = WIDTH'(angle);
      quadrant_in = 3'(quad);
      in_valid    = 1'b1;
      out_ready   = (bp == 0);
      tick();
      in_valid = 1'b0;
      check_eq("busy_in_ready", in_ready, 0);
      check_eq("busy_out_valid", out_valid, 0);
      n = 0;
      if (poke) begin
         tick();
         n++;
         tick();
         n++;
         in_valid    = 1'b1;
         angle_in    = WIDTH'(100000);
         quadrant_in = 3'd7;
         tick();
         n++;
         check_eq("poke_in_ready", in_ready, 0);
         tick();
         n++;
         in_valid    = 1'b0;
         angle_in    = WIDTH'(angle);
         quadrant_in = 3'(quad);
      end
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      check_eq("latency", n, ITERATIONS);
      check_eq("done_in_ready", in_ready, 0);
      hx = x_out;
      hy = y_out;
      hq = quadrant_out;
      for (int k = 0; k < bp; k++) begin
         tick();
         check_eq("bp_out_valid", out_valid, 1);
         check_eq("bp_in_ready", in_ready, 0);
         check_eq("bp_x_stable", x_out, hx);
         check_eq("bp_y_stable", y_out, hy);
         check_eq("bp_q_stable", quadrant_out, hq);
      end
      out_ready = 1'b1;
      check_eq("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
      end
      check_near("x_out", x_out, e.exp_x);
      check_near("y_out", y_out, e.exp_y);
      check_eq("quadrant_out", quadrant_out, e.quad);
      tick();
      check_eq("post_out_valid", out_valid, 0);
      check_eq("post_in_ready", in_ready, 1);
      check_near("post_hold_x", x_out, e.exp_x);
      check_eq("post_hold_q", quadrant_out, e.quad);
   endtask

   // Directed sequence.
   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      angle_in    = '0;
      quadrant_in = '0;
      tick();
      tick();
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_x_out", x_out, 0);
      check_eq("rst_y_out", y_out, 0);
      check_eq("rst_quadrant", quadrant_out, 0);
      rst = 1'b0;
      tick();

      do_job(0, 1, 0, 1'b0);
      do_job(205887, 2, 0, 1'b0);
      do_job(411775, 3, 0, 1'b0);
      do_job(150000, 4, 10, 1'b0);
      do_job(60000, 6, 0, 1'b1);

      // out_ready while idle must not produce a result
      out_ready = 1'b1;
      tick();
      tick();
      check_eq("idle_out_valid", out_valid, 0);
      check_eq("idle_in_ready", in_ready, 1);

      // reset while rotating discards the job
      angle_in    = WIDTH'(300000);
      quadrant_in = 3'd5;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (7) tick();
      check_eq("mid_in_ready", in_ready, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_in_ready", in_ready, 1);
      check_eq("mid_rst_out_valid", out_valid, 0);
      check_eq("mid_rst_x_out", x_out, 0);
      check_eq("mid_rst_y_out", y_out, 0);
      check_eq("mid_rst_quadrant", quadrant_out, 0);
      cnt = 0;
      repeat (30) begin
         tick();
         if (out_valid) cnt++;
      end
      check_eq("no_stale_result", cnt, 0);

      do_job(350000, 0, 0, 1'b0);
      do_job(int'($urandom_range(411775, 0)), 5, 0, 1'b0);
      do_job(int'($urandom_range(411775, 0)), 7, 3, 1'b0);

      check_eq("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
